// File: rtl/jtcps1_obj_line_draw.sv
// ----------------------------------------------------------------------------
// jtcps1_obj_line_draw
//
// Draws the sprite (object) pixels of one scan line. The line table builder
// has left up to 128 entries of 4 words each for this line. The list ends at
// the first entry whose word0 is 16'hFFFF, or after entry 127. For each entry
// this block reads word0..word2 and fetches the two 32-bit halves of the
// 64-bit tile row from graphics ROM. It then decodes the 4bpp planar data and
// writes every opaque pixel (color != 4'hF) into the object line buffer.
//
// Entry words:
//   word0 = {4'd0, vsub[3:0], vflip, hflip, pal[4:0]}
//           (vflip is already folded into vsub; bit 7 is unused)
//   word1 = tile code
//   word2 = x position
//   word3 = unused, never read
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse; (re)starts drawing from entry 0
//   done       high when the line is finished, held until the next start
//   line_addr  table word address {entry[6:0], sub[1:0]}
//   line_data  table word, valid one cycle after line_addr changes
//   rom_addr   {code[15:0], vsub[3:0]}
//   rom_half   selects the 32-bit half of the 64-bit tile row
//   rom_cs     ROM request, held until rom_ok
//   rom_ok     rom_data is valid for the current rom_addr/rom_half
//   rom_data   4 planes x 8 pixels, one plane per byte
//   buf_addr   pixel x position in the line buffer (wraps modulo 512)
//   buf_data   {pal[4:0], color[3:0]}
//   buf_wr     pixel write strobe
// ----------------------------------------------------------------------------
module jtcps1_obj_line_draw #(
    parameter int ROMW = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            done,
    output logic [8:0]      line_addr,
    input  logic [15:0]     line_data,
    output logic [ROMW-1:0] rom_addr,
    output logic            rom_half,
    output logic            rom_cs,
    input  logic            rom_ok,
    input  logic [31:0]     rom_data,
    output logic [8:0]      buf_addr,
    output logic [8:0]      buf_data,
    output logic            buf_wr
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        REQ,
        DRAW,
        DONE
    } state_t;

    state_t      state;
    logic [6:0]  entry;
    logic [3:0]  vsub;
    logic        hflip;
    logic [4:0]  pal;
    logic [15:0] code;
    logic [8:0]  xpos;
    logic [31:0] pix;
    logic [2:0]  k;
    logic        half_idx;
    logic [3:0]  color;

    // The pixel being drawn always sits at the same bit of each plane byte:
    // bit 7 when drawing left to right, bit 0 when the tile is mirrored. The
    // shift register moves the next pixel into that position every cycle.
    always_comb begin
        color = 4'h0;
        if (hflip) begin
            color = {pix[24], pix[16], pix[8], pix[0]};
        end else begin
            color = {pix[31], pix[23], pix[15], pix[7]};
        end
    end

    // Main sequencer. The table RAM has one cycle of read latency, so
    // line_addr is always set one state ahead of the state that captures the
    // word. A start pulse in any state restarts the line from entry 0. This
    // drops any pending ROM request so rom_cs is low for several cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b1;
            line_addr <= 9'd0;
            rom_cs    <= 1'b0;
            rom_half  <= 1'b0;
            rom_addr  <= '0;
            buf_wr    <= 1'b0;
            buf_addr  <= 9'd0;
            buf_data  <= 9'd0;
            entry     <= 7'd0;
            vsub      <= 4'd0;
            hflip     <= 1'b0;
            pal       <= 5'd0;
            code      <= 16'd0;
            xpos      <= 9'd0;
            pix       <= 32'd0;
            k         <= 3'd0;
            half_idx  <= 1'b0;
        end else begin
            buf_wr <= 1'b0;
            if (start) begin
                entry     <= 7'd0;
                done      <= 1'b0;
                rom_cs    <= 1'b0;
                line_addr <= 9'd0;
                state     <= RD0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RD0: begin
                        line_addr <= {entry, 2'd1};
                        state     <= RD1;
                    end
                    RD1: begin
                        if (line_data == 16'hFFFF) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            vsub      <= line_data[11:8];
                            hflip     <= line_data[5];
                            pal       <= line_data[4:0];
                            line_addr <= {entry, 2'd2};
                            state     <= RD2;
                        end
                    end
                    RD2: begin
                        code  <= line_data;
                        state <= RD3;
                    end
                    RD3: begin
                        // A mirrored tile starts from the upper ROM half so
                        // that its rightmost pixels land at x.
                        xpos     <= line_data[8:0];
                        rom_addr <= ROMW'({code, vsub});
                        rom_half <= hflip;
                        rom_cs   <= 1'b1;
                        half_idx <= 1'b0;
                        state    <= REQ;
                    end
                    REQ: begin
                        if (rom_cs && rom_ok) begin
                            pix    <= rom_data;
                            rom_cs <= 1'b0;
                            k      <= 3'd0;
                            state  <= DRAW;
                        end
                    end
                    DRAW: begin
                        buf_wr   <= (color != 4'hF);
                        buf_addr <= xpos + 9'({half_idx, k});
                        buf_data <= {pal, color};
                        k        <= k + 3'd1;
                        if (hflip) begin
                            pix <= (pix >> 1) & 32'h7F7F_7F7F;
                        end else begin
                            pix <= (pix << 1) & 32'hFEFE_FEFE;
                        end
                        if (k == 3'd7) begin
                            if (!half_idx) begin
                                half_idx <= 1'b1;
                                rom_half <= ~hflip;
                                rom_cs   <= 1'b1;
                                state    <= REQ;
                            end else if (entry == 7'd127) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                entry     <= entry + 7'd1;
                                line_addr <= {entry + 7'd1, 2'd0};
                                state     <= RD0;
                            end
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtcps1_obj_line_draw.sv
// ----------------------------------------------------------------------------
// tb_jtcps1_obj_line_draw
//
// Bench for the object line drawer. It contains a line table RAM with one
// cycle of read latency and a ROM responder with programmable latency. Each
// table entry that is loaded also pushes the expected ROM requests and pixel
// writes, decoded from the planar formula, onto queues. Negedge monitors pop
// those queues as the design issues requests and writes.
// ----------------------------------------------------------------------------
module tb_jtcps1_obj_line_draw;

    localparam int ROMW   = 20;
    localparam int BUDGET = 10000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            done;
    logic [8:0]      line_addr;
    logic [15:0]     line_data;
    logic [ROMW-1:0] rom_addr;
    logic            rom_half;
    logic            rom_cs;
    logic            rom_ok;
    logic [31:0]     rom_data;
    logic [8:0]      buf_addr;
    logic [8:0]      buf_data;
    logic            buf_wr;

    always #5 clk = ~clk;

    jtcps1_obj_line_draw #(.ROMW(ROMW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .done      (done),
        .line_addr (line_addr),
        .line_data (line_data),
        .rom_addr  (rom_addr),
        .rom_half  (rom_half),
        .rom_cs    (rom_cs),
        .rom_ok    (rom_ok),
        .rom_data  (rom_data),
        .buf_addr  (buf_addr),
        .buf_data  (buf_data),
        .buf_wr    (buf_wr)
    );

    // Line table RAM with registered read
    logic [15:0] tbl [0:511];
    always @(posedge clk) line_data <= tbl[line_addr];

    // ROM responder: answers a held request after rom_lat extra cycles
    int          rom_lat;
    int          rom_cnt;
    logic        rom_ok_r;
    logic        inject_ok;
    bit          rom_hash;
    logic [31:0] rom_d0;
    logic [31:0] rom_d1;

    function automatic logic [31:0] rom_val(input logic [19:0] a, input logic h);
        if (rom_hash) return (32'(a) * 32'h9E37_79B1) ^ {h, 31'h02A5_A5A5};
        return h ? rom_d1 : rom_d0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            rom_ok_r <= 1'b0;
            rom_cnt  <= 0;
        end else if (rom_ok_r) begin
            rom_ok_r <= 1'b0;
            rom_cnt  <= 0;
        end else if (!rom_cs) begin
            rom_cnt <= 0;
        end else if (rom_cnt >= rom_lat) begin
            rom_ok_r <= 1'b1;
            rom_data <= rom_val(rom_addr, rom_half);
        end else begin
            rom_cnt <= rom_cnt + 1;
        end
    end
    assign rom_ok = rom_ok_r | inject_ok;

    // Scoreboard state
    logic [17:0] exp_wr[$];
    logic [20:0] exp_rom[$];
    logic [17:0] wr_e;
    logic [20:0] rom_e;
    bit          sb_en;
    int          n_wr;
    int          n_rom;
    logic [8:0]  max_la;
    int          n_vec;
    int          n_err;

    always @(negedge clk) begin
        if (!rst && sb_en) begin
            if (buf_wr) begin
                n_wr++;
                n_vec++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL wr_extra: got addr=%h data=%h, required no write", buf_addr, buf_data);
                end else begin
                    wr_e = exp_wr.pop_front();
                    if ({buf_addr, buf_data} !== wr_e) begin
                        n_err++;
                        $display("[TB] FAIL wr: got addr=%h data=%h, required addr=%h data=%h",
                                 buf_addr, buf_data, wr_e[17:9], wr_e[8:0]);
                    end
                end
            end
            if (rom_cs && rom_ok) begin
                n_rom++;
                n_vec++;
                if (exp_rom.size() == 0) begin
                    n_err++;
                    $display("[TB] FAIL rom_extra: got addr=%h half=%b, required no request", rom_addr, rom_half);
                end else begin
                    rom_e = exp_rom.pop_front();
                    if ({rom_addr, rom_half} !== rom_e) begin
                        n_err++;
                        $display("[TB] FAIL rom_req: got addr=%h half=%b, required addr=%h half=%b",
                                 rom_addr, rom_half, rom_e[20:1], rom_e[0]);
                    end
                end
            end
            if (line_addr > max_la) max_la = line_addr;
        end
    end

    // Planar decode straight from the pixel formula
    function automatic logic [3:0] spec_color(input logic [31:0] d, input int k, input logic hf);
        if (hf) return {d[24+k], d[16+k], d[8+k], d[k]};
        return {d[31-k], d[23-k], d[15-k], d[7-k]};
    endfunction

    task automatic clear_table();
        for (int i = 0; i < 512; i++) tbl[i] = 16'hFFFF;
    endtask

    task automatic clear_sb();
        exp_wr.delete();
        exp_rom.delete();
        n_wr   = 0;
        n_rom  = 0;
        max_la = 9'd0;
    endtask

    // Loads one entry and pushes the ROM requests and pixel writes it implies
    task automatic add_entry(input int idx, input logic [15:0] w0, input logic [15:0] code,
                             input logic [15:0] xw);
        logic [19:0] ra;
        logic        hs;
        logic [31:0] d;
        logic [3:0]  c;
        logic [8:0]  a;
        tbl[idx*4]     = w0;
        tbl[idx*4 + 1] = code;
        tbl[idx*4 + 2] = xw;
        tbl[idx*4 + 3] = 16'hDEAD;
        ra = {code, w0[11:8]};
        for (int h = 0; h < 2; h++) begin
            hs = (h == 0) ? w0[5] : ~w0[5];
            d  = rom_val(ra, hs);
            exp_rom.push_back({ra, hs});
            for (int k = 0; k < 8; k++) begin
                c = spec_color(d, k, w0[5]);
                a = xw[8:0] + 9'(h*8 + k);
                if (c != 4'hF) exp_wr.push_back({a, w0[4:0], c});
            end
        end
    endtask

    task automatic start_and_wait(input int budget, output bit ok);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (done !== 1'b1)      begin n_err++; $display("[TB] FAIL rst_done: got %b required 1", done); end
        n_vec++; if (line_addr !== 9'd0) begin n_err++; $display("[TB] FAIL rst_line_addr: got %h required 0", line_addr); end
        n_vec++; if (rom_cs !== 1'b0)    begin n_err++; $display("[TB] FAIL rst_rom_cs: got %b required 0", rom_cs); end
        n_vec++; if (rom_half !== 1'b0)  begin n_err++; $display("[TB] FAIL rst_rom_half: got %b required 0", rom_half); end
        n_vec++; if (rom_addr !== '0)    begin n_err++; $display("[TB] FAIL rst_rom_addr: got %h required 0", rom_addr); end
        n_vec++; if (buf_wr !== 1'b0)    begin n_err++; $display("[TB] FAIL rst_buf_wr: got %b required 0", buf_wr); end
        n_vec++; if (buf_addr !== 9'd0)  begin n_err++; $display("[TB] FAIL rst_buf_addr: got %h required 0", buf_addr); end
        n_vec++; if (buf_data !== 9'd0)  begin n_err++; $display("[TB] FAIL rst_buf_data: got %h required 0", buf_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs the loaded table once and checks completion and traffic counts
    task automatic run_and_check(input string name);
        bit ok;
        int nw;
        int nr;
        nw = exp_wr.size();
        nr = exp_rom.size();
        sb_en = 1'b1;
        start_and_wait(BUDGET, ok);
        sb_en = 1'b0;
        n_vec++; if (!ok)       begin n_err++; $display("[TB] FAIL %s_done: got done=%b, required 1 within budget", name, done); end
        n_vec++; if (n_wr != nw)  begin n_err++; $display("[TB] FAIL %s_wr_count: got %0d required %0d", name, n_wr, nw); end
        n_vec++; if (n_rom != nr) begin n_err++; $display("[TB] FAIL %s_rom_count: got %0d required %0d", name, n_rom, nr); end
    endtask

    task automatic test_single();
        $display("[TB] single entry");
        clear_table(); clear_sb();
        rom_hash = 1'b0; rom_d0 = 32'h0; rom_d1 = 32'h0; rom_lat = 1;
        add_entry(0, 16'h0305, 16'h1234, 16'h0040);
        n_vec++; if (exp_wr.size() != 16) begin n_err++; $display("[TB] FAIL single_model: got %0d writes, required 16", exp_wr.size()); end
        run_and_check("single");
    endtask

    task automatic test_transparency();
        $display("[TB] transparency");
        clear_table(); clear_sb();
        rom_hash = 1'b0; rom_d0 = 32'hFFFF_FFFF; rom_d1 = 32'hFFFF_FFFF; rom_lat = 2;
        add_entry(0, 16'h0712, 16'h4321, 16'h0100);
        run_and_check("transp");
        n_vec++; if (n_wr != 0) begin n_err++; $display("[TB] FAIL transp_no_wr: got %0d writes required 0", n_wr); end
    endtask

    task automatic test_hflip();
        $display("[TB] hflip");
        clear_table(); clear_sb();
        rom_hash = 1'b0; rom_d1 = 32'h0101_0101; rom_d0 = 32'h0; rom_lat = 0;
        add_entry(0, 16'h0227, 16'h00AB, 16'h0080);
        run_and_check("hflip");
        n_vec++; if (n_wr != 15) begin n_err++; $display("[TB] FAIL hflip_skip: got %0d writes required 15", n_wr); end
    endtask

    task automatic test_wrap_multi();
        $display("[TB] wrap and multi-entry");
        clear_table(); clear_sb();
        rom_hash = 1'b1; rom_lat = 3;
        add_entry(0, 16'h0A91, 16'hBEEF, 16'h01FC);
        add_entry(1, 16'h0F7E, 16'h0001, 16'h01F8);
        add_entry(2, 16'h0C40, 16'hFFFF, 16'hFE05);
        run_and_check("wrap");
    endtask

    task automatic test_full_table();
        logic [15:0] w0;
        $display("[TB] full table");
        clear_table(); clear_sb();
        rom_hash = 1'b1; rom_lat = 0;
        for (int i = 0; i < 128; i++) begin
            w0 = 16'($urandom_range(0, 16'h0FFF));
            add_entry(i, w0, 16'($urandom), 16'($urandom));
        end
        run_and_check("full");
        n_vec++; if (n_rom != 256)    begin n_err++; $display("[TB] FAIL full_rom_reqs: got %0d required 256", n_rom); end
        n_vec++; if (max_la !== 9'h1FE) begin n_err++; $display("[TB] FAIL full_max_line_addr: got %h required 1fe", max_la); end
    endtask

    task automatic test_spurious_ok();
        $display("[TB] rom_ok while idle");
        @(negedge clk);
        inject_ok = 1'b1;
        @(negedge clk);
        inject_ok = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (rom_cs !== 1'b0) begin n_err++; $display("[TB] FAIL spur_rom_cs: got %b required 0", rom_cs); end
        n_vec++; if (done !== 1'b1)   begin n_err++; $display("[TB] FAIL spur_done: got %b required 1", done); end
        n_vec++; if (buf_wr !== 1'b0) begin n_err++; $display("[TB] FAIL spur_buf_wr: got %b required 0", buf_wr); end
    endtask

    task automatic test_restart();
        bit found;
        $display("[TB] restart during draw");
        clear_table(); clear_sb();
        rom_hash = 1'b1; rom_lat = 1;
        for (int i = 0; i < 6; i++) add_entry(i, 16'(16'h0100 * i + i), 16'(16'h1111 * i), 16'(16'h0020 * i));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rom_cs && line_addr == 9'h00E) begin found = 1'b1; break; end
            @(negedge clk);
        end
        for (int i = 0; i < 200 && found; i++) begin
            if (!rom_cs) break;
            @(negedge clk);
        end
        @(negedge clk);
        n_vec++; if (!found) begin n_err++; $display("[TB] FAIL restart_reach: got no entry 3 request, required one"); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (line_addr !== 9'd0) begin n_err++; $display("[TB] FAIL restart_line_addr: got %h required 0", line_addr); end
        n_vec++; if (done !== 1'b0)      begin n_err++; $display("[TB] FAIL restart_done: got %b required 0", done); end
        n_vec++; if (rom_cs !== 1'b0)    begin n_err++; $display("[TB] FAIL restart_rom_cs: got %b required 0", rom_cs); end
        clear_sb();
        for (int i = 0; i < 6; i++) add_entry(i, 16'(16'h0100 * i + i), 16'(16'h1111 * i), 16'(16'h0020 * i));
        sb_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (done) begin found = 1'b1; break; end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        sb_en = 1'b0;
        n_vec++; if (!found)          begin n_err++; $display("[TB] FAIL restart_finish: got done=%b required 1", done); end
        n_vec++; if (n_rom != 12)     begin n_err++; $display("[TB] FAIL restart_rom_count: got %0d required 12", n_rom); end
        n_vec++; if (exp_wr.size() != 0) begin n_err++; $display("[TB] FAIL restart_wr_left: got %0d pending required 0", exp_wr.size()); end
    endtask

    task automatic test_reset_mid_req();
        bit found;
        $display("[TB] reset during rom request");
        clear_table(); clear_sb();
        rom_hash = 1'b0; rom_d0 = 32'h0; rom_d1 = 32'h0; rom_lat = 20;
        add_entry(0, 16'h0101, 16'h5555, 16'h0010);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rom_cs) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (!found) begin n_err++; $display("[TB] FAIL rstreq_reach: got rom_cs=%b required 1", rom_cs); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (rom_cs !== 1'b0)    begin n_err++; $display("[TB] FAIL rstreq_rom_cs: got %b required 0", rom_cs); end
        n_vec++; if (done !== 1'b1)      begin n_err++; $display("[TB] FAIL rstreq_done: got %b required 1", done); end
        n_vec++; if (line_addr !== 9'd0) begin n_err++; $display("[TB] FAIL rstreq_line_addr: got %h required 0", line_addr); end
        repeat (4) @(negedge clk);
        n_vec++; if (rom_cs !== 1'b0)    begin n_err++; $display("[TB] FAIL rstreq_idle: got rom_cs=%b required 0", rom_cs); end
        clear_sb();
    endtask

    task automatic test_back_to_back();
        $display("[TB] back to back lines");
        clear_table(); clear_sb();
        rom_hash = 1'b1; rom_lat = 1;
        add_entry(0, 16'h0E33, 16'h2468, 16'h0150);
        add_entry(1, 16'h0019, 16'h1357, 16'h0008);
        run_and_check("b2b_first");
        clear_sb();
        add_entry(0, 16'h0E33, 16'h2468, 16'h0150);
        add_entry(1, 16'h0019, 16'h1357, 16'h0008);
        run_and_check("b2b_second");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inject_ok = 1'b0; sb_en = 1'b0;
        rom_lat = 1; rom_hash = 1'b0; rom_d0 = 32'h0; rom_d1 = 32'h0;
        n_vec = 0; n_err = 0;
        clear_table();
        clear_sb();
        test_reset();
        test_single();
        test_transparency();
        test_hflip();
        test_wrap_multi();
        test_full_table();
        test_spurious_ok();
        test_restart();
        test_reset_mid_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
